// File: rtl/audio_pkg.sv
// Shared audio definitions for the ADC capture and DAC transmit paths.
// Sample and stereo types, channel-level constant and slot-event encoding.
package audio_pkg;

    localparam int AUDIO_WIDTH = 24;

    // Level of the word clock while the left channel is on the wire.
    localparam logic LRCK_LEFT_LEVEL = 1'b0;

    typedef logic signed [AUDIO_WIDTH-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

    typedef enum logic [1:0] {
        EVT_NONE  = 2'd0,
        EVT_LEFT  = 2'd1,
        EVT_RIGHT = 2'd2
    } slot_evt_t;

endpackage

// File: rtl/audio_sync_edge.sv
// Two-flop synchronizer plus a history flop for one asynchronous audio clock.
// Provides the synchronized level and single-cycle rise/fall events.
module audio_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_hist;
    assign o_fall  = ~r_sync & r_hist;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Parallel-to-serial DAC transmitter: one-entry stereo holding register feeding
// an MSB-first shifter clocked by falling edges of the externally supplied bck.
module i2s_tx_serializer
    import audio_pkg::*;
#(
    parameter int   WIDTH     = AUDIO_WIDTH,
    parameter logic LEFT_LRCK = LRCK_LEFT_LEVEL,
    parameter bit   I2S_DELAY = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_bck,
    input  logic             i_lrck,
    input  logic [WIDTH-1:0] i_left,
    input  logic [WIDTH-1:0] i_right,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_sdata,
    output logic             o_underrun,
    output logic             o_frame_start
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             w_bck_fall;
    logic             w_bck_rise;
    logic             w_bck_level;
    logic             w_lrck_s;
    logic             w_lrck_rise;
    logic             w_lrck_fall;
    logic             w_unused;

    logic             r_armed;
    logic             r_lrck_q;
    logic             r_full;
    logic [WIDTH-1:0] r_hold_left;
    logic [WIDTH-1:0] r_hold_right;
    logic [WIDTH-1:0] r_right;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_d;

    slot_evt_t        w_evt;
    logic             w_accept;
    logic [WIDTH-1:0] w_load_word;
    logic             w_s;

    audio_sync_edge u_bck_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (i_bck),
        .o_level (w_bck_level),
        .o_rise  (w_bck_rise),
        .o_fall  (w_bck_fall)
    );

    audio_sync_edge u_lrck_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (i_lrck),
        .o_level (w_lrck_s),
        .o_rise  (w_lrck_rise),
        .o_fall  (w_lrck_fall)
    );

    assign w_unused = ^{w_bck_level, w_bck_rise, w_lrck_rise, w_lrck_fall};

    assign o_ready  = ~r_full;
    assign w_accept = i_valid & ~r_full;

    // The first bck fall after reset only records lrck, so it can never start a slot.
    always_comb begin
        w_evt = EVT_NONE;
        if (w_bck_fall && r_armed && (w_lrck_s != r_lrck_q)) begin
            w_evt = (w_lrck_s == LEFT_LRCK) ? EVT_LEFT : EVT_RIGHT;
        end
    end

    always_comb begin
        w_load_word = r_right;
        if (w_evt == EVT_LEFT) begin
            w_load_word = r_full ? r_hold_left : '0;
        end
    end

    always_comb begin
        w_s = 1'b0;
        if (w_evt != EVT_NONE) begin
            w_s = w_load_word[WIDTH-1];
        end else if (r_cnt != '0) begin
            w_s = r_shift[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed       <= 1'b0;
            r_lrck_q      <= 1'b0;
            r_full        <= 1'b0;
            r_hold_left   <= '0;
            r_hold_right  <= '0;
            r_right       <= '0;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_d           <= 1'b0;
            o_sdata       <= 1'b0;
            o_underrun    <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_underrun    <= 1'b0;
            o_frame_start <= 1'b0;

            // Accepting needs !r_full, so it never collides with a left start consuming the pair.
            if (w_accept) begin
                r_full       <= 1'b1;
                r_hold_left  <= i_left;
                r_hold_right <= i_right;
            end

            if (w_bck_fall) begin
                r_lrck_q <= w_lrck_s;
                r_armed  <= 1'b1;

                if (w_evt != EVT_NONE) begin
                    r_shift <= w_load_word << 1;
                    r_cnt   <= CW'(WIDTH - 1);
                end else if (r_cnt != '0) begin
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt - CW'(1);
                end

                if (w_evt == EVT_LEFT) begin
                    r_right <= r_full ? r_hold_right : '0;
                    if (r_full) begin
                        r_full        <= 1'b0;
                        o_frame_start <= 1'b1;
                    end else begin
                        o_underrun    <= 1'b1;
                    end
                end

                r_d     <= w_s;
                o_sdata <= I2S_DELAY ? r_d : w_s;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: a left-justified and an I2S instance share stimulus;
// a slot-position model predicts every serial bit, ready level and pulse count.
module tb_i2s_tx_serializer;

    localparam int W = 24;

    logic          clk;
    logic          rst_n;
    logic          i_bck;
    logic          i_lrck;
    logic [W-1:0]  i_left;
    logic [W-1:0]  i_right;
    logic          i_valid;
    logic          o_ready0, o_sdata0, o_underrun0, o_frame_start0;
    logic          o_ready1, o_sdata1, o_underrun1, o_frame_start1;

    i2s_tx_serializer #(.WIDTH(W), .LEFT_LRCK(1'b0), .I2S_DELAY(1'b0)) u_dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_bck         (i_bck),
        .i_lrck        (i_lrck),
        .i_left        (i_left),
        .i_right       (i_right),
        .i_valid       (i_valid),
        .o_ready       (o_ready0),
        .o_sdata       (o_sdata0),
        .o_underrun    (o_underrun0),
        .o_frame_start (o_frame_start0)
    );

    i2s_tx_serializer #(.WIDTH(W), .LEFT_LRCK(1'b0), .I2S_DELAY(1'b1)) u_dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_bck         (i_bck),
        .i_lrck        (i_lrck),
        .i_left        (i_left),
        .i_right       (i_right),
        .i_valid       (i_valid),
        .o_ready       (o_ready1),
        .o_sdata       (o_sdata1),
        .o_underrun    (o_underrun1),
        .o_frame_start (o_frame_start1)
    );

    // Clock and global time limit.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot position since the last word-clock change.
    logic [W-1:0]  m_word  = '0;
    logic [W-1:0]  m_right = '0;
    logic [W-1:0]  m_hl    = '0;
    logic [W-1:0]  m_hr    = '0;
    logic          m_full  = 1'b0;
    logic          m_armed = 1'b0;
    logic          m_lrck  = 1'b0;
    logic          m_d     = 1'b0;
    int            m_p     = W;
    logic [2*W-1:0] m_pend[$];
    logic          exp_s0  = 1'b0;
    logic          exp_s1  = 1'b0;
    int            exp_fs  = 0;
    int            exp_ur  = 0;

    task automatic model_take();
        logic [2*W-1:0] pr;
        if (!m_full && m_pend.size() > 0) begin
            pr     = m_pend.pop_front();
            m_hl   = pr[2*W-1:W];
            m_hr   = pr[W-1:0];
            m_full = 1'b1;
        end
    endtask

    task automatic model_fall(input logic lv);
        logic s;
        if (m_armed && (lv != m_lrck)) begin
            m_p = 0;
            if (lv == 1'b0) begin
                if (m_full) begin
                    m_word  = m_hl;
                    m_right = m_hr;
                    m_full  = 1'b0;
                    exp_fs++;
                end else begin
                    m_word  = '0;
                    m_right = '0;
                    exp_ur++;
                end
                model_take();
            end else begin
                m_word = m_right;
            end
        end else if (m_p < W) begin
            m_p++;
        end
        s       = (m_p < W) ? m_word[W-1-m_p] : 1'b0;
        exp_s0  = s;
        exp_s1  = m_d;
        m_d     = s;
        m_lrck  = lv;
        m_armed = 1'b1;
    endtask

    task automatic model_reset();
        m_word  = '0;
        m_right = '0;
        m_full  = 1'b0;
        m_armed = 1'b0;
        m_d     = 1'b0;
        m_p     = W;
        exp_s0  = 1'b0;
        exp_s1  = 1'b0;
        m_pend.delete();
    endtask

    // Driver: holds each pair on i_valid until the handshake, back-to-back if queued.
    logic [2*W-1:0] drv_q[$];
    logic           acc_pending = 1'b0;

    initial begin
        i_valid = 1'b0;
        i_left  = '0;
        i_right = '0;
        forever begin
            @(negedge clk);
            if (acc_pending) begin
                void'(drv_q.pop_front());
                i_valid     = 1'b0;
                acc_pending = 1'b0;
            end
            if (!i_valid && drv_q.size() > 0) begin
                i_left  = drv_q[0][2*W-1:W];
                i_right = drv_q[0][W-1:0];
                i_valid = 1'b1;
            end
            if (i_valid && o_ready1) acc_pending = 1'b1;
        end
    end

    task automatic offer(input logic [W-1:0] l, input logic [W-1:0] r);
        drv_q.push_back({l, r});
        m_pend.push_back({l, r});
        model_take();
    endtask

    // Pulse and ready-cycle monitors.
    int fs_cnt  = 0;
    int ur_cnt  = 0;
    int rdy_cnt = 0;

    always @(negedge clk) begin
        if (o_frame_start1) fs_cnt++;
        if (o_underrun1)    ur_cnt++;
        if (o_ready1)       rdy_cnt++;
    end

    // Compare process, fired mid-way through each bck low phase.
    event        ev_mid;
    logic [31:0] cap0 = '0;
    logic [31:0] cap1 = '0;
    logic        nz   = 1'b0;

    always @(ev_mid) begin
        chk("sdata_lj",        {31'b0, o_sdata0}, {31'b0, exp_s0});
        chk("sdata_i2s",       {31'b0, o_sdata1}, {31'b0, exp_s1});
        chk("ready_lj",        {31'b0, o_ready0}, {31'b0, ~m_full});
        chk("ready_i2s",       {31'b0, o_ready1}, {31'b0, ~m_full});
        chk("frame_start_cnt", fs_cnt, exp_fs);
        chk("underrun_cnt",    ur_cnt, exp_ur);
        cap0 = {cap0[30:0], o_sdata0};
        cap1 = {cap1[30:0], o_sdata1};
        if (o_sdata0 || o_sdata1) nz = 1'b1;
    end

    // One bck period of 16 clk; lrck changes together with the bck fall.
    task automatic bck_cycle(input logic lv);
        @(negedge clk);
        i_bck  = 1'b0;
        i_lrck = lv;
        model_fall(lv);
        repeat (7) @(negedge clk);
        ->ev_mid;
        @(negedge clk);
        i_bck = 1'b1;
        repeat (7) @(negedge clk);
    endtask

    task automatic run_slot(input logic lv, input int n);
        for (int i = 0; i < n; i++) bck_cycle(lv);
    endtask

    int base;

    initial begin
        rst_n  = 1'b0;
        i_bck  = 1'b1;
        i_lrck = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_sdata_lj",  {31'b0, o_sdata0},       32'd0);
        chk("rst_sdata_i2s", {31'b0, o_sdata1},       32'd0);
        chk("rst_ready",     {31'b0, o_ready1},       32'd1);
        chk("rst_fs",        {31'b0, o_frame_start1}, 32'd0);
        chk("rst_ur",        {31'b0, o_underrun1},    32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // I2S and left-justified serialization of one pair.
        base = fs_cnt;
        offer(24'hA5A5A5, 24'h5A5A5A);
        run_slot(1'b1, 32);
        run_slot(1'b0, 32);
        chk("t1_left_i2s", cap1, 32'h52D2D280);
        chk("t1_left_lj",  cap0, 32'hA5A5A500);
        run_slot(1'b1, 32);
        chk("t1_right_i2s", cap1, 32'h2D2D2D00);
        chk("t1_right_lj",  cap0, 32'h5A5A5A00);
        chk("t1_fs_once", fs_cnt - base, 32'd1);

        // Three frames with nothing offered.
        base = ur_cnt;
        nz   = 1'b0;
        for (int f = 0; f < 3; f++) begin
            run_slot(1'b0, 32);
            run_slot(1'b1, 32);
        end
        chk("t3_underruns", ur_cnt - base, 32'd3);
        chk("t3_all_zero",  {31'b0, nz},   32'd0);

        // Backpressure with two queued pairs.
        run_slot(1'b0, 32);
        offer(24'h000001, 24'h000002);
        offer(24'h7FFFFF, 24'h800000);
        run_slot(1'b1, 1);
        rdy_cnt = 0;
        run_slot(1'b1, 31);
        run_slot(1'b0, 32);
        chk("t4_p1_left",  cap0, 32'h00000100);
        run_slot(1'b1, 32);
        chk("t4_p1_right", cap0, 32'h00000200);
        chk("t4_ready_one_cycle", rdy_cnt, 32'd1);
        run_slot(1'b0, 32);
        chk("t4_p2_left",  cap0, 32'h7FFFFF00);
        run_slot(1'b1, 32);
        chk("t4_p2_right", cap0, 32'h80000000);

        // Reset at bit 10 of a left word.
        offer(24'hFFFFFF, 24'hFFFFFF);
        run_slot(1'b1, 2);
        run_slot(1'b0, 11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_sdata_lj",  {31'b0, o_sdata0}, 32'd0);
        chk("t5_rst_sdata_i2s", {31'b0, o_sdata1}, 32'd0);
        chk("t5_rst_ready",     {31'b0, o_ready1}, 32'd1);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run_slot(1'b0, 21);
        run_slot(1'b1, 32);
        run_slot(1'b0, 32);
        run_slot(1'b1, 32);

        // Short 16-bck slots truncate each word.
        offer(24'hABCDEF, 24'h13579B);
        run_slot(1'b1, 4);
        run_slot(1'b0, 16);
        run_slot(1'b1, 16);
        chk("t6_short_lj",  cap0, 32'hABCD1357);
        chk("t6_short_i2s", cap1, 32'h55E689AB);
        run_slot(1'b0, 16);
        run_slot(1'b1, 16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
